// File: rtl/slink_pkg.sv
// Shared SLINK definitions used by the RX MAC (and the TX MAC).
// Contents: K-character codes, CRC16 constants, frame status bit indices
// and the MAC framing state enum.
package slink_pkg;

  localparam logic [7:0]  K_IDLE   = 8'hBC;   // K28.5
  localparam logic [7:0]  K_SOF    = 8'hFB;   // K27.7
  localparam logic [7:0]  K_EOF    = 8'hFD;   // K29.7

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Bit positions inside frm_stat
  localparam int STAT_CRC  = 0;
  localparam int STAT_LEN  = 1;
  localparam int STAT_CODE = 2;
  localparam int STAT_OVF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } slink_state_e;

endpackage

// File: rtl/ex_crc16_d8.sv
// Combinational CRC16-CCITT update for one byte, MSB first, no reflection.
// Ports:
//   crc_in   in  16  current CRC register
//   data     in  8   byte to fold in
//   crc_out  out 16  CRC after the byte
module ex_crc16_d8
  import slink_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    crc_out = c;
  end

endmodule

// File: rtl/ex_slink_macrx.sv
// SLINK receive MAC. Delimits frames on K-characters, packs byte pairs into
// 16-bit words, checks CRC16 and writes {sop,eop,data16} words to the RX
// frame FIFO, with a per-frame status pulse.
// Ports:
//   clk_12_5m, rst_12_5m          clock, synchronous active-high reset
//   pcsrx_macrx_data/kchar/dval/err  decoded byte stream from the PCS RX
//   mmrx_macrx_afull              FIFO almost full (words due are discarded)
//   macrx_mmrx_data/dval          word write port {sop,eop,data}
//   macrx_frm_done/frm_stat       end-of-frame pulse and {ovf,code,len,crc}
//   slink_rx_sop                  pulse when an SOF is accepted
//
// state   | meaning
// IDLE    | waiting for SOF, everything else ignored
// DATA    | inside a frame, collecting words into the 2-deep holdback
// DROP    | payload too long, swallow bytes until EOF or SOF
module ex_slink_macrx
  import slink_pkg::*;
#(
  parameter int MAX_WORDS = 512,
  parameter int CNT_W     = 10
) (
  input  logic        clk_12_5m,
  input  logic        rst_12_5m,
  input  logic [7:0]  pcsrx_macrx_data,
  input  logic        pcsrx_macrx_kchar,
  input  logic        pcsrx_macrx_dval,
  input  logic        pcsrx_macrx_err,
  input  logic        mmrx_macrx_afull,
  output logic [17:0] macrx_mmrx_data,
  output logic        macrx_mmrx_dval,
  output logic        macrx_frm_done,
  output logic [3:0]  macrx_frm_stat,
  output logic        slink_rx_sop
);

  // Total completed words (payload + CRC word) that still fit in a frame.
  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(MAX_WORDS + 1);

  slink_state_e     state_q, state_nxt;
  logic             phase_q, phase_nxt;
  logic [7:0]       hi_q, hi_nxt;
  logic [1:0]       hcnt_q, hcnt_nxt;
  logic [15:0]      h0_q, h0_nxt, h1_q, h1_nxt;
  logic [CNT_W-1:0] wcnt_q, wcnt_nxt;
  logic [15:0]      crc_q, crc_nxt, crc_upd;
  logic             ovf_q, ovf_nxt;
  logic             sop_pend_q, sop_pend_nxt;

  logic [17:0]      data_q, data_nxt;
  logic             wr_q, wr_nxt;
  logic             done_q, done_nxt;
  logic [3:0]       stat_q, stat_nxt;
  logic             rx_sop_q, rx_sop_nxt;

  logic             emit_req;
  logic             emit_eop;
  logic [15:0]      emit_word;
  logic             len_err;
  logic             is_sof, is_eof, is_idle;

  ex_crc16_d8 u_crc (
    .crc_in  (crc_q),
    .data    (pcsrx_macrx_data),
    .crc_out (crc_upd)
  );

  assign is_sof  = pcsrx_macrx_kchar && (pcsrx_macrx_data == K_SOF);
  assign is_eof  = pcsrx_macrx_kchar && (pcsrx_macrx_data == K_EOF);
  assign is_idle = pcsrx_macrx_kchar && (pcsrx_macrx_data == K_IDLE);

  always_comb begin
    state_nxt    = state_q;
    phase_nxt    = phase_q;
    hi_nxt       = hi_q;
    hcnt_nxt     = hcnt_q;
    h0_nxt       = h0_q;
    h1_nxt       = h1_q;
    wcnt_nxt     = wcnt_q;
    crc_nxt      = crc_q;
    ovf_nxt      = ovf_q;
    sop_pend_nxt = sop_pend_q;
    data_nxt     = data_q;
    wr_nxt       = 1'b0;
    done_nxt     = 1'b0;
    stat_nxt     = 4'h0;
    rx_sop_nxt   = 1'b0;
    emit_req     = 1'b0;
    emit_eop     = 1'b0;
    emit_word    = h0_q;
    len_err      = 1'b0;

    if (pcsrx_macrx_dval) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_sof && !pcsrx_macrx_err) state_nxt = ST_DATA;
        end

        ST_DATA: begin
          if (pcsrx_macrx_err || (pcsrx_macrx_kchar && !is_idle && !is_sof && !is_eof)) begin
            done_nxt            = 1'b1;
            stat_nxt[STAT_OVF]  = ovf_q;
            stat_nxt[STAT_CODE] = 1'b1;
            hcnt_nxt            = 2'd0;
            state_nxt           = ST_IDLE;
          end else if (is_sof) begin
            done_nxt           = 1'b1;
            stat_nxt[STAT_OVF] = ovf_q;
            stat_nxt[STAT_LEN] = 1'b1;
          end else if (is_eof) begin
            // H1 holds the CRC word, so H0 is the last payload word.
            len_err  = phase_q || (hcnt_q != 2'd2) || (wcnt_q > WCNT_LAST);
            emit_req = !len_err;
            emit_eop = 1'b1;
            done_nxt = 1'b1;
            stat_nxt[STAT_OVF] = ovf_q || (!len_err && mmrx_macrx_afull);
            stat_nxt[STAT_LEN] = len_err;
            stat_nxt[STAT_CRC] = !len_err && (crc_q != 16'h0000);
            hcnt_nxt  = 2'd0;
            state_nxt = ST_IDLE;
          end else if (!pcsrx_macrx_kchar) begin
            crc_nxt = crc_upd;
            if (!phase_q) begin
              hi_nxt    = pcsrx_macrx_data;
              phase_nxt = 1'b1;
            end else begin
              phase_nxt = 1'b0;
              if (wcnt_q == WCNT_LAST) begin
                state_nxt = ST_DROP;
                hcnt_nxt  = 2'd0;
              end else begin
                wcnt_nxt = wcnt_q + CNT_W'(1);
                unique case (hcnt_q)
                  2'd0: begin
                    h0_nxt   = {hi_q, pcsrx_macrx_data};
                    hcnt_nxt = 2'd1;
                  end
                  2'd1: begin
                    h1_nxt   = {hi_q, pcsrx_macrx_data};
                    hcnt_nxt = 2'd2;
                  end
                  default: begin
                    emit_req = 1'b1;
                    h0_nxt   = h1_q;
                    h1_nxt   = {hi_q, pcsrx_macrx_data};
                  end
                endcase
              end
            end
          end
        end

        ST_DROP: begin
          if (!pcsrx_macrx_err && (is_sof || is_eof)) begin
            done_nxt           = 1'b1;
            stat_nxt[STAT_OVF] = ovf_q;
            stat_nxt[STAT_LEN] = 1'b1;
            state_nxt          = ST_IDLE;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase

      // A new frame may start while the old one is being closed out.
      if (is_sof && !pcsrx_macrx_err) begin
        state_nxt    = ST_DATA;
        phase_nxt    = 1'b0;
        hcnt_nxt     = 2'd0;
        wcnt_nxt     = '0;
        crc_nxt      = CRC_INIT;
        ovf_nxt      = 1'b0;
        sop_pend_nxt = 1'b1;
        rx_sop_nxt   = 1'b1;
      end
    end

    // A word due while the FIFO is almost full is lost and mutes the frame.
    if (emit_req) begin
      sop_pend_nxt = 1'b0;
      if (!ovf_q) begin
        if (mmrx_macrx_afull) begin
          ovf_nxt = 1'b1;
        end else begin
          wr_nxt   = 1'b1;
          data_nxt = {sop_pend_q, emit_eop, emit_word};
        end
      end
    end
  end

  always_ff @(posedge clk_12_5m) begin
    if (rst_12_5m) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      hi_q       <= 8'h00;
      hcnt_q     <= 2'd0;
      h0_q       <= 16'h0000;
      h1_q       <= 16'h0000;
      wcnt_q     <= '0;
      crc_q      <= CRC_INIT;
      ovf_q      <= 1'b0;
      sop_pend_q <= 1'b0;
      data_q     <= 18'h0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      stat_q     <= 4'h0;
      rx_sop_q   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      phase_q    <= phase_nxt;
      hi_q       <= hi_nxt;
      hcnt_q     <= hcnt_nxt;
      h0_q       <= h0_nxt;
      h1_q       <= h1_nxt;
      wcnt_q     <= wcnt_nxt;
      crc_q      <= crc_nxt;
      ovf_q      <= ovf_nxt;
      sop_pend_q <= sop_pend_nxt;
      data_q     <= data_nxt;
      wr_q       <= wr_nxt;
      done_q     <= done_nxt;
      stat_q     <= stat_nxt;
      rx_sop_q   <= rx_sop_nxt;
    end
  end

  assign macrx_mmrx_data = data_q;
  assign macrx_mmrx_dval = wr_q;
  assign macrx_frm_done  = done_q;
  assign macrx_frm_stat  = stat_q;
  assign slink_rx_sop    = rx_sop_q;

endmodule

// File: tb/tb_ex_slink_macrx.sv
// Scoreboard bench for ex_slink_macrx: expected words and frame status are
// queued as frames are driven and compared as the DUT produces them.
module tb_ex_slink_macrx;

  localparam int MAX_WORDS = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        kchar, dval, err, afull;
  logic [17:0] m_data;
  logic        m_dval, frm_done, rx_sop;
  logic [3:0]  frm_stat;

  typedef struct packed {
    logic [3:0] stat;
    logic       sop_same;
  } stat_exp_t;

  logic [17:0] exp_w[$];
  stat_exp_t   exp_s[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          sop_seen = 0;
  int          sop_exp = 0;

  always #40 clk = ~clk;

  ex_slink_macrx #(.MAX_WORDS(MAX_WORDS), .CNT_W(10)) dut (
    .clk_12_5m         (clk),
    .rst_12_5m         (rst),
    .pcsrx_macrx_data  (data),
    .pcsrx_macrx_kchar (kchar),
    .pcsrx_macrx_dval  (dval),
    .pcsrx_macrx_err   (err),
    .mmrx_macrx_afull  (afull),
    .macrx_mmrx_data   (m_data),
    .macrx_mmrx_dval   (m_dval),
    .macrx_frm_done    (frm_done),
    .macrx_frm_stat    (frm_stat),
    .slink_rx_sop      (rx_sop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift-register form of CRC16-CCITT, byte folded into the top.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_dval) begin
      if (exp_w.size() == 0) chk("word_unexpected", {14'h0, m_data}, 32'h0);
      else chk("word", {14'h0, m_data}, {14'h0, exp_w.pop_front()});
    end
    if (frm_done) begin
      if (exp_s.size() == 0) chk("done_unexpected", 32'h1, 32'h0);
      else begin
        stat_exp_t e;
        e = exp_s.pop_front();
        chk("stat", {28'h0, frm_stat}, {28'h0, e.stat});
        chk("sop_with_done", {31'h0, rx_sop}, {31'h0, e.sop_same});
      end
    end
    if (rx_sop) sop_seen++;
  end

  task automatic put(input logic [7:0] d, input logic k, input logic e, input logic af);
    @(negedge clk);
    dval = 1'b1; data = d; kchar = k; err = e; afull = af;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dval = 1'b0; data = 8'h00; kchar = 1'b0; err = 1'b0; afull = 1'b0;
    end
  endtask

  task automatic sof();
    put(8'hFB, 1'b1, 1'b0, 1'b0);
    sop_exp++;
  endtask

  task automatic eof();
    put(8'hFD, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_stat(input logic [3:0] s, input logic same);
    stat_exp_t e;
    e.stat = s; e.sop_same = same;
    exp_s.push_back(e);
  endtask

  // Payload word j (1-based) is base + (j-1)*step. af_word marks the word
  // whose completing byte is sent with afull=1 (word n+1 is the CRC word).
  task automatic send_frame(input int n, input logic [15:0] base, input logic [15:0] step,
                            input bit flip, input int af_word, input bit gaps);
    logic [15:0] c, w;
    bit ovf;
    int ept;
    c = 16'hFFFF;
    if (n > MAX_WORDS) begin
      for (int j = 1; j < MAX_WORDS; j++) begin
        w = base + 16'(j - 1) * step;
        exp_w.push_back({(j == 1), 1'b0, w});
      end
      push_stat(4'b0010, 1'b0);
    end else if (n == 0) begin
      push_stat(4'b0010, 1'b0);
    end else begin
      ovf = (af_word >= 3) && (af_word <= n + 1);
      for (int j = 1; j <= n; j++) begin
        ept = (j == n) ? n + 2 : j + 2;
        w = base + 16'(j - 1) * step;
        if (!(ovf && ept >= af_word)) exp_w.push_back({(j == 1), (j == n), w});
      end
      push_stat({ovf, 2'b00, flip}, 1'b0);
    end
    sof();
    for (int j = 1; j <= n + 1; j++) begin
      if (j <= n) begin
        w = base + 16'(j - 1) * step;
        c = crc_upd(crc_upd(c, w[15:8]), w[7:0]);
      end else begin
        w = {c[15:8], c[7:0] ^ {7'h0, flip}};
      end
      put(w[15:8], 1'b0, 1'b0, 1'b0);
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
      put(w[7:0], 1'b0, 1'b0, (j == af_word));
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
    end
    eof();
    idle(3);
  endtask

  initial begin
    logic [15:0] c;
    rst = 1'b1; dval = 1'b0; data = 8'h00; kchar = 1'b0; err = 1'b0; afull = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dval", {31'h0, m_dval}, 32'h0);
    chk("rst_done", {31'h0, frm_done}, 32'h0);
    chk("rst_stat", {28'h0, frm_stat}, 32'h0);
    chk("rst_sop", {31'h0, rx_sop}, 32'h0);
    chk("rst_data", {14'h0, m_data}, 32'h0);

    // 1: basic two-word frame, 2: corrupted CRC lo byte
    send_frame(2, 16'h1122, 16'h2222, 1'b0, 0, 1'b0);
    send_frame(2, 16'h1122, 16'h2222, 1'b1, 0, 1'b0);
    send_frame(6, 16'hA5A5, 16'h1357, 1'b0, 0, 1'b1);

    // 3: one-word frame with gaps and an idle K inside
    c = crc_upd(crc_upd(16'hFFFF, 8'hAB), 8'hCD);
    exp_w.push_back(18'h3_ABCD);
    push_stat(4'b0000, 1'b0);
    sof();
    put(8'hAB, 1'b0, 1'b0, 1'b0);
    idle(1);
    put(8'hBC, 1'b1, 1'b0, 1'b0);
    put(8'hCD, 1'b0, 1'b0, 1'b0);
    idle(2);
    put(c[15:8], 1'b0, 1'b0, 1'b0);
    put(c[7:0], 1'b0, 1'b0, 1'b0);
    eof();
    idle(3);
    chk("sop_cnt_a", sop_seen, sop_exp);

    // 4: odd byte count, then length boundary either side of MAX_WORDS
    push_stat(4'b0010, 1'b0);
    sof();
    put(8'h11, 1'b0, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0, 1'b0);
    put(8'h33, 1'b0, 1'b0, 1'b0);
    eof();
    idle(3);
    send_frame(0, 16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    send_frame(MAX_WORDS, 16'h0100, 16'h0001, 1'b0, 0, 1'b0);
    send_frame(MAX_WORDS + 1, 16'h0200, 16'h0003, 1'b0, 0, 1'b0);

    // 5: code error aborts; stray bytes in IDLE ignored; SOF restarts mid-frame
    push_stat(4'b0100, 1'b0);
    sof();
    put(8'h11, 1'b0, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0, 1'b0);
    put(8'h33, 1'b0, 1'b1, 1'b0);
    idle(2);
    put(8'h55, 1'b0, 1'b0, 1'b0);
    eof();
    idle(3);
    sof();
    put(8'h11, 1'b0, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0, 1'b0);
    put(8'h33, 1'b0, 1'b0, 1'b0);
    put(8'h44, 1'b0, 1'b0, 1'b0);
    push_stat(4'b0010, 1'b1);
    exp_w.push_back(18'h3_5566);
    push_stat(4'b0000, 1'b0);
    c = crc_upd(crc_upd(16'hFFFF, 8'h55), 8'h66);
    sof();
    put(8'h55, 1'b0, 1'b0, 1'b0);
    put(8'h66, 1'b0, 1'b0, 1'b0);
    put(c[15:8], 1'b0, 1'b0, 1'b0);
    put(c[7:0], 1'b0, 1'b0, 1'b0);
    eof();
    idle(3);
    chk("sop_cnt_b", sop_seen, sop_exp);

    // 6: afull while word 2 of 4 is due, then reset mid-frame
    send_frame(4, 16'h1000, 16'h0101, 1'b0, 4, 1'b0);
    exp_w.push_back(18'h2_1122);
    sof();
    put(8'h11, 1'b0, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0, 1'b0);
    put(8'h33, 1'b0, 1'b0, 1'b0);
    put(8'h44, 1'b0, 1'b0, 1'b0);
    put(8'h55, 1'b0, 1'b0, 1'b0);
    put(8'h66, 1'b0, 1'b0, 1'b0);
    put(8'h77, 1'b0, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_data", {14'h0, m_data}, 32'h0);
    chk("rst2_done", {31'h0, frm_done}, 32'h0);
    eof();
    idle(3);
    send_frame(3, 16'hBEEF, 16'h0F0F, 1'b0, 0, 1'b1);

    idle(5);
    chk("sop_cnt_end", sop_seen, sop_exp);
    chk("words_left", exp_w.size(), 32'h0);
    chk("stats_left", exp_s.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
